dcache_responder: RTL

- Data-side memory responder for the pipelined RV32I core. Serves the core's D-port read/write/byte-enable/resp protocol.
- Direct-mapped, write-back, write-allocate cache: 32-bit word interface on the CPU side, 256-bit line interface to physical memory.
- Sits between the core's data port and the memory arbiter/line adapter.

---
 rtl/dcache_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back write-allocate data cache for the RV32I D-port
module dcache_responder #(
  parameter int S_INDEX  = 4,
  parameter int S_OFFSET = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [31:0]               mem_address,
  input  logic [3:0]                mem_byte_enable,
  input  logic [31:0]               mem_wdata,
  output logic [31:0]               mem_rdata,
  output logic                      mem_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [31:0]               pmem_address,
  output logic [(8<<S_OFFSET)-1:0]  pmem_wdata,
  input  logic [(8<<S_OFFSET)-1:0]  pmem_rdata,
  input  logic                      pmem_resp
);
  localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
  localparam int SETS  = 1 << S_INDEX;
  localparam int LINE  = 8 << S_OFFSET;
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
  state_t state;
  logic [31:0] addr_q, a, word, mword, bm;
  logic [SETS-1:0] valid_q, dirty_q;
  logic [S_TAG-1:0] tag_q [SETS];
  logic [LINE-1:0] data_q [SETS];
  logic [LINE-1:0] base, mline;
  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0] tg;
  logic [S_OFFSET-3:0] wsel;
  logic req, hit, eval, fill_done, unused;
  assign unused = ^a[1:0];
  assign pmem_wdata = data_q[addr_q[S_OFFSET +: S_INDEX]];
  // Lookup on the live bus address in IDLE, on the captured address while a miss is serviced
  always_comb begin
    a = state == IDLE ? mem_address : addr_q;
    idx = a[S_OFFSET +: S_INDEX];
    tg = a[31 -: S_TAG];
    wsel = a[S_OFFSET-1:2];
    req = mem_read | mem_write;
    fill_done = state == FILL && pmem_resp;
    eval = (state == IDLE && req) || fill_done;
    hit = fill_done || (valid_q[idx] && tag_q[idx] == tg);
    base = fill_done ? pmem_rdata : data_q[idx];
    word = base[{wsel, 5'b0} +: 32];
    bm = {{8{mem_byte_enable[3]}}, {8{mem_byte_enable[2]}}, {8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};
    mword = mem_write ? (mem_wdata & bm) | (word & ~bm) : word;
    mline = base;
    mline[{wsel, 5'b0} +: 32] = mword;
  end
  // Line and tag storage need no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (eval && hit && (fill_done || mem_write)) data_q[idx] <= mline;
    if (fill_done) tag_q[idx] <= tg;
  end
  // Control FSM; a hit (including the refilled reissue) answers on the edge that enters CHECK
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      mem_rdata <= '0;
      mem_resp <= 1'b0;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
      pmem_address <= '0;
    end else begin
      mem_resp <= 1'b0;
      if (eval && hit && req) begin
        mem_resp <= 1'b1;
        mem_rdata <= mword;
      end
      if (eval && hit) dirty_q[idx] <= (dirty_q[idx] & ~fill_done) | (mem_write & |mem_byte_enable);
      unique case (state)
        IDLE: if (req) begin
          addr_q <= mem_address;
          state <= CHECK;
        end
        CHECK: if (mem_resp || !req || hit) state <= IDLE;
        else if (dirty_q[idx]) begin
          state <= WRITEBACK;
          pmem_write <= 1'b1;
          pmem_address <= {tag_q[idx], idx, {S_OFFSET{1'b0}}};
        end else begin
          state <= FILL;
          pmem_read <= 1'b1;
          pmem_address <= {tg, idx, {S_OFFSET{1'b0}}};
        end
        WRITEBACK: if (pmem_resp) begin
          state <= FILL;
          dirty_q[idx] <= 1'b0;
          pmem_write <= 1'b0;
          pmem_read <= 1'b1;
          pmem_address <= {tg, idx, {S_OFFSET{1'b0}}};
        end
        FILL: if (pmem_resp) begin
          state <= CHECK;
          valid_q[idx] <= 1'b1;
          pmem_read <= 1'b0;
        end
      endcase
    end
  end
endmodule
